// File: rtl/seq_alu_if.sv
// Handshake and operand/result bundle between the control unit and seq_alu.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [4:0]       FunSel;
    logic             WF;
    logic             Start;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] ALUOut;
    logic [WIDTH-1:0] HiOut;
    logic [3:0]       FlagsOut;

    // The control unit drives requests and watches Busy/Done and the results
    modport master (
        output A, B, FunSel, WF, Start,
        input  Busy, Done, ALUOut, HiOut, FlagsOut
    );

    // The ALU consumes requests and produces registered results
    modport slave (
        input  A, B, FunSel, WF, Start,
        output Busy, Done, ALUOut, HiOut, FlagsOut
    );
endinterface

// File: rtl/seq_alu.sv
// Registered datapath ALU: 16 single-cycle ops plus iterative unsigned
// multiply (shift-add) and divide (restoring), one bit per cycle.
// Flags are {Z,C,N,O}; bits an op does not define keep their old value.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic     Clock,
    input  logic     Reset,
    seq_alu_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             div_q, div_d;
    logic             wf_q, wf_d;
    logic [WIDTH-1:0] alu_out_q, alu_out_d;
    logic [WIDTH-1:0] hi_out_q, hi_out_d;
    logic [3:0]       flags_q, flags_d;
    logic             done_q, done_d;
    logic             busy;

    logic             accept;
    logic             is_multi;
    logic             last_step;
    logic [3:0]       sc_op;
    logic             c_in;
    logic [WIDTH:0]   sc_sum;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c;
    logic             sc_o;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_q;

    // Reserved multi-cycle codes fall back to single-cycle op 0000 (pass A)
    assign accept    = (state_q == IDLE) && bus.Start;
    assign is_multi  = bus.FunSel[4] && (bus.FunSel[3:1] == 3'b000);
    assign sc_op     = bus.FunSel[4] ? 4'd0 : bus.FunSel[3:0];
    assign c_in      = flags_q[2];
    assign last_step = (cnt_q == CNT_W'(1));

    // Single-cycle result plus its carry/overflow candidates (held unless the op defines them)
    always_comb begin
        sc_sum = '0;
        sc_res = bus.A;
        sc_c   = c_in;
        sc_o   = flags_q[0];
        case (sc_op)
            4'b0000: sc_res = bus.A;
            4'b0001: sc_res = bus.B;
            4'b0010: sc_res = ~bus.A;
            4'b0011: sc_res = ~bus.B;
            4'b0100, 4'b0101: begin
                sc_sum = {1'b0, bus.A} + {1'b0, bus.B}
                       + {{WIDTH{1'b0}}, (sc_op == 4'b0101) & c_in};
                sc_res = sc_sum[WIDTH-1:0];
                sc_c   = sc_sum[WIDTH];
                sc_o   = (bus.A[WIDTH-1] == bus.B[WIDTH-1])
                       && (sc_res[WIDTH-1] != bus.A[WIDTH-1]);
            end
            4'b0110: begin
                sc_sum = {1'b0, bus.A} - {1'b0, bus.B};
                sc_res = sc_sum[WIDTH-1:0];
                sc_c   = sc_sum[WIDTH];
                sc_o   = (bus.A[WIDTH-1] != bus.B[WIDTH-1])
                       && (sc_res[WIDTH-1] != bus.A[WIDTH-1]);
            end
            4'b0111: sc_res = bus.A & bus.B;
            4'b1000: sc_res = bus.A | bus.B;
            4'b1001: sc_res = bus.A ^ bus.B;
            4'b1010: sc_res = ~(bus.A & bus.B);
            4'b1011: begin
                sc_res = {bus.A[WIDTH-2:0], 1'b0};
                sc_c   = bus.A[WIDTH-1];
            end
            4'b1100: begin
                sc_res = {1'b0, bus.A[WIDTH-1:1]};
                sc_c   = bus.A[0];
            end
            4'b1101: begin
                sc_res = {bus.A[WIDTH-1], bus.A[WIDTH-1:1]};
                sc_c   = bus.A[0];
            end
            4'b1110: begin
                sc_res = {bus.A[WIDTH-2:0], c_in};
                sc_c   = bus.A[WIDTH-1];
            end
            default: begin
                sc_res = {c_in, bus.A[WIDTH-1:1]};
                sc_c   = bus.A[0];
            end
        endcase
    end

    // One iteration step: acc holds the product high half / partial remainder, q the low half / quotient
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q, q_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (div_q) begin
            if (!div_diff[WIDTH]) begin
                step_acc = div_diff[WIDTH-1:0];
                step_q   = {q_q[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = div_shift[WIDTH-1:0];
                step_q   = {q_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_acc = mul_sum[WIDTH:1];
            step_q   = {mul_sum[0], q_q[WIDTH-1:1]};
        end
    end

    // State register; reset discards any op in flight
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: only multiply/divide leave IDLE, and they return after the last step
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && is_multi) state_d = ITER;
            ITER:    if (last_step) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output: Busy follows the iterating state, so a Start while busy is never seen by accept
    always_comb begin
        busy = (state_q == ITER);
    end

    // Datapath next values: latch operands, iterate, or commit results and pulse Done
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        q_d       = q_q;
        opnd_d    = opnd_q;
        div_d     = div_q;
        wf_d      = wf_q;
        alu_out_d = alu_out_q;
        hi_out_d  = hi_out_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        if (accept) begin
            if (is_multi) begin
                div_d  = bus.FunSel[0];
                opnd_d = bus.FunSel[0] ? bus.B : bus.A;
                q_d    = bus.FunSel[0] ? bus.A : bus.B;
                acc_d  = '0;
                cnt_d  = CNT_W'(WIDTH);
                wf_d   = bus.WF;
            end else begin
                alu_out_d = sc_res;
                hi_out_d  = '0;
                done_d    = 1'b1;
                if (bus.WF) begin
                    flags_d = {(sc_res == '0), sc_c, sc_res[WIDTH-1], sc_o};
                end
            end
        end else if (busy) begin
            acc_d = step_acc;
            q_d   = step_q;
            cnt_d = cnt_q - CNT_W'(1);
            if (last_step) begin
                alu_out_d = step_q;
                hi_out_d  = step_acc;
                done_d    = 1'b1;
                if (wf_q) begin
                    if (div_q) begin
                        flags_d = {(step_q == '0), flags_q[2], step_q[WIDTH-1], (opnd_q == '0)};
                    end else begin
                        flags_d = {((step_acc == '0) && (step_q == '0)), flags_q[2],
                                   step_acc[WIDTH-1], flags_q[0]};
                    end
                end
            end
        end
    end

    // Datapath and result registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            opnd_q    <= '0;
            div_q     <= 1'b0;
            wf_q      <= 1'b0;
            alu_out_q <= '0;
            hi_out_q  <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            opnd_q    <= opnd_d;
            div_q     <= div_d;
            wf_q      <= wf_d;
            alu_out_q <= alu_out_d;
            hi_out_q  <= hi_out_d;
            flags_q   <= flags_d;
            done_q    <= done_d;
        end
    end

    assign bus.Busy     = busy;
    assign bus.Done     = done_q;
    assign bus.ALUOut   = alu_out_q;
    assign bus.HiOut    = hi_out_q;
    assign bus.FlagsOut = flags_q;

endmodule
